// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer and its input stages.
//   db_state_t      : debouncer FSM state encoding (ZERO, WAIT1, ONE, WAIT0)
//   SYNC_STAGES_MIN : shortest synchroniser chain that is metastability-safe
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// N-flop synchroniser chain for a single asynchronous bit.
// Ports:
//   clk   in  1  destination clock, rising edge
//   reset in  1  asynchronous, active-high; clears every stage to 0
//   d     in  1  asynchronous input bit
//   q     out 1  d delayed by STAGES clk edges, safe to use in the clk domain
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/early_debounce_fsm.sv
// Early-detection switch debouncer. The first sensed transition of the
// synchronised input flips db immediately; the input is then ignored for a
// lockout of 2**CNT_BITS cycles so contact bounce cannot produce extra edges.
// db feeds a downstream edge detector that turns it into one-cycle pulses.
// Ports:
//   clk   in  1  system clock, rising edge
//   reset in  1  asynchronous, active-high reset
//   in    in  1  raw, bouncing, asynchronous switch input
//   db    out 1  debounced level, decoded from the state register only
//   busy  out 1  high while a lockout (WAIT1/WAIT0) is running
module early_debounce_fsm
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_BITS    = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic db,
  output logic busy
);

  // A chain shorter than two flops is not a synchroniser; clamp it.
  localparam int STAGES_EFF = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic                s_in;
  db_state_t           state_reg;
  db_state_t           state_next;
  logic [CNT_BITS-1:0] counter;
  logic [CNT_BITS-1:0] counter_next;

  // Input synchronisation: the FSM only ever looks at s_in.
  bit_synchronizer #(
    .STAGES(STAGES_EFF)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (in),
    .q    (s_in)
  );

  // State and lockout counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ZERO;
      counter   <= '0;
    end else begin
      state_reg <= state_next;
      counter   <= counter_next;
    end
  end

  // Next state and Moore outputs. The counter is cleared everywhere except
  // while counting inside a WAIT state, so every lockout starts from 0 and
  // lasts counter values 0..CNT_MAX, i.e. exactly 2**CNT_BITS cycles.
  // Leaving a WAIT state always lands in the matching stable state; if s_in
  // already disagrees, the opposite WAIT follows one cycle later.
  always_comb begin
    state_next   = state_reg;
    counter_next = '0;
    db           = 1'b0;
    busy         = 1'b0;
    case (state_reg)
      ZERO: begin
        if (s_in) begin
          state_next = WAIT1;
        end
      end
      WAIT1: begin
        db   = 1'b1;
        busy = 1'b1;
        if (counter == CNT_MAX) begin
          state_next = ONE;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      ONE: begin
        db = 1'b1;
        if (!s_in) begin
          state_next = WAIT0;
        end
      end
      WAIT0: begin
        busy = 1'b1;
        if (counter == CNT_MAX) begin
          state_next = ZERO;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      default: begin
        state_next = ZERO;
      end
    endcase
  end

endmodule
